// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and constants for the waitstate bus RAM
package mips_bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} ram_state_t;
  typedef logic [31:0] word_t;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/mips_bus_ram_waitstate_lfsr.sv
// mips_bus_lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11), advances when step is high
//   clk, reset (async active-low, loads seed), step, seed[15:0], value[15:0]
module mips_bus_lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);
  logic [15:0] value_q, value_d;
  always_comb value_d = step ? {value_q[14:0], value_q[15] ^ value_q[13] ^ value_q[12] ^ value_q[10]} : value_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) value_q <= seed;
    else value_q <= value_d;
  assign value = value_q;
endmodule

// File: rtl/mips_bus_ram_waitstate.sv
// mips_bus_ram_waitstate: Avalon-MM-style word RAM that stalls every access with waitrequest
//   clk, reset (async active-low); address/read/write/writedata/byteenable request in;
//   waitrequest, readdata, protocol_error (sticky) out.
//   MIPS_RAM_RANDOM_WAIT_EN adds an LFSR-driven 0..7 extra stall cycles per access.
module mips_bus_ram_waitstate
  import mips_bus_pkg::*;
#(
  parameter string       RAM_INIT_FILE = "",
  parameter int          ADDR_WIDTH    = 12,
  parameter int          WAIT_CYCLES   = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        protocol_error
);
  word_t mem [2**ADDR_WIDTH];
  initial for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] = '0;
  ram_state_t state_q, state_d;
  logic [8:0] cnt_q, cnt_d, wait_len;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  word_t wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] be_q, be_d;
  logic wr_q, wr_d, err_q, err_d;
  logic req, unused_ok;
  assign req = read | write;
`ifdef MIPS_RAM_RANDOM_WAIT_EN
  logic [15:0] lfsr_value;
  mips_bus_lfsr16 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .step (state_q == IDLE && req),
    .seed (LFSR_SEED),
    .value(lfsr_value)
  );
  assign wait_len = 9'(WAIT_CYCLES) + {6'd0, lfsr_value[2:0]};
  assign unused_ok = ^{address[31:ADDR_WIDTH+2], address[1:0], lfsr_value[15:3]};
`else
  assign wait_len = 9'(WAIT_CYCLES);
  assign unused_ok = ^{address[31:ADDR_WIDTH+2], address[1:0], LFSR_SEED};
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        addr_d  = address[ADDR_WIDTH+1:2];
        wdata_d = writedata;
        be_d    = byteenable;
        wr_d    = write;
        cnt_d   = wait_len;
        err_d   = err_q | (read & write);
        state_d = (wait_len == 9'd0) ? ACK : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 9'd1;
        err_d   = err_q | ~req;
        state_d = (cnt_q == 9'd1) ? ACK : WAIT;
      end
      ACK: begin
        rdata_d = wr_q ? rdata_q : mem[addr_q];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  always_ff @(posedge clk)
    if (state_q == ACK && wr_q)
      for (int i = 0; i < BYTES_PER_WORD; i++)
        if (be_q[i]) mem[addr_q][8*i+:8] <= wdata_q[8*i+:8];
  assign waitrequest    = req && state_q != ACK;
  assign readdata       = (state_q == ACK && !wr_q) ? mem[addr_q] : rdata_q;
  assign protocol_error = err_q;
endmodule

// File: tb/tb_mips_bus_ram_waitstate.sv
// tb_mips_bus_ram_waitstate: random bus traffic checked every cycle against a transaction-level model
module tb_mips_bus_ram_waitstate;
  localparam int WAITC = 1;
  logic clk = 0, reset = 0, read = 0, write = 0, waitrequest, protocol_error;
  logic [31:0] address = 0, writedata = 0, readdata;
  logic [3:0] byteenable = 0;
  always #5 clk = ~clk;

  mips_bus_ram_waitstate #(.RAM_INIT_FILE(""), .ADDR_WIDTH(4), .WAIT_CYCLES(WAITC), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .protocol_error(protocol_error)
  );

  int n_cmp = 0, n_bad = 0;
  logic [31:0] mem_m [16];
  logic [31:0] last_rd = 0, exp_rd = 0, last_ack_rd = 0;
  bit err_m = 0, exp_w = 0, exp_e = 0, last_err = 0;
  bit [15:0] last_wp = 0;
`ifdef MIPS_RAM_RANDOM_WAIT_EN
  bit [15:0] lf = 16'hACE1;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("waitrequest", {31'd0, waitrequest}, {31'd0, exp_w});
    chk("readdata", readdata, exp_rd);
    chk("protocol_error", {31'd0, protocol_error}, {31'd0, exp_e});
  end

  task automatic cyc(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input bit ew, input logic [31:0] er, input bit ee,
                     output bit ow, output logic [31:0] ord, output bit oe);
    read = r; write = w; address = a; writedata = wd; byteenable = be;
    exp_w = ew; exp_rd = er; exp_e = ee;
    @(negedge clk);
    ow = waitrequest; ord = readdata; oe = protocol_error;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit ow, oe;
    logic [31:0] ord;
    repeat (n) cyc(0, 0, $urandom(), $urandom(), 4'($urandom()), 0, last_rd, err_m, ow, ord, oe);
  endtask

  // One access: stall length L, acceptance in cycle L+1, optional drop during the stall,
  // optional scrambling of the live pins after cycle 0 (latched values must win).
  task automatic xfer(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input bit drop, input bit scr);
    int L, wi, drop_at;
    bit hold, ow, oe, s;
    logic [31:0] ord;
    wi = int'(a[5:2]);
    L = WAITC;
`ifdef MIPS_RAM_RANDOM_WAIT_EN
    L = WAITC + int'(lf[2:0]);
    lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
`endif
    drop_at = (drop && L > 0) ? int'($urandom_range(1, L)) : 0;
    last_wp = '0;
    for (int k = 0; k <= L + 1; k++) begin
      hold = !(drop_at > 0 && k >= drop_at);
      if (k >= 1 && r && w) err_m = 1;
      if (drop_at > 0 && k > drop_at) err_m = 1;
      s = scr && k > 0;
      cyc(hold && r, hold && w, s ? $urandom() : a, s ? $urandom() : wd, s ? 4'($urandom()) : be,
          hold && k <= L, (k == L + 1 && r && !w) ? mem_m[wi] : last_rd, err_m, ow, ord, oe);
      last_wp[k] = ow;
      if (k == L + 1) begin
        last_ack_rd = ord;
        last_err = oe;
      end
    end
    if (w) begin
      for (int i = 0; i < 4; i++) if (be[i]) mem_m[wi][8*i+:8] = wd[8*i+:8];
    end else if (r) last_rd = mem_m[wi];
  endtask

  task automatic rnd(input int n, input bit errs);
    bit r, w;
    for (int i = 0; i < n; i++) begin
      r = bit'($urandom_range(0, 1));
      w = !r;
      if (errs && $urandom_range(0, 7) == 0) begin r = 1; w = 1; end
      xfer(r, w, $urandom(), $urandom(), 4'($urandom_range(0, 15)),
           errs && $urandom_range(0, 3) == 0, bit'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    bit ow, oe;
    logic [31:0] ord;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    @(negedge clk);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_err", {31'd0, protocol_error}, 32'h0);
    chk("rst_wait_noreq", {31'd0, waitrequest}, 32'h0);
    read = 1; exp_w = 1;
    @(negedge clk);
    chk("rst_wait_req", {31'd0, waitrequest}, 32'h1);
    @(posedge clk); #1;
    read = 0; exp_w = 0; reset = 1;
    xfer(0, 1, 32'h4, 32'h0006C012, 4'hF, 0, 0);
    xfer(1, 0, 32'h4, 32'h0, 4'h0, 0, 0);
`ifndef MIPS_RAM_RANDOM_WAIT_EN
    chk("t1_wait_pattern", {16'd0, last_wp}, 32'h3);
`endif
    chk("t1_rdata", last_ack_rd, 32'h0006C012);
    xfer(0, 1, 32'h8, 32'hDEADBEEF, 4'b0101, 0, 0);
    idle(1);
    xfer(1, 0, 32'h8, 32'h0, 4'h0, 0, 0);
    chk("t2_lanes", last_ack_rd, 32'h00AD00EF);
    xfer(1, 0, 32'hABCD0047, 32'h0, 4'h0, 0, 0);
    chk("alias_read", last_ack_rd, 32'h0006C012);
    xfer(0, 1, 32'h4, 32'hFFFFFFFF, 4'h0, 0, 0);
    xfer(1, 0, 32'h4, 32'h0, 4'h0, 0, 0);
    chk("be0_write", last_ack_rd, 32'h0006C012);
    rnd(150, 0);
    xfer(1, 1, 32'hC, 32'h12345678, 4'hF, 0, 0);
    chk("t4_err", {31'd0, last_err}, 32'h1);
    xfer(1, 0, 32'hC, 32'h0, 4'h0, 0, 0);
    chk("t4_rdata", last_ack_rd, 32'h12345678);
    rnd(60, 1);
    xfer(0, 1, 32'h20, 32'h5A5A1234, 4'hF, 0, 0);
    cyc(0, 1, 32'h20, 32'hFFFFFFFF, 4'hF, 1, last_rd, err_m, ow, ord, oe);
    reset = 0;
    last_rd = 0; err_m = 0;
`ifdef MIPS_RAM_RANDOM_WAIT_EN
    lf = 16'hACE1;
`endif
    repeat (2) cyc(0, 1, 32'h20, 32'hFFFFFFFF, 4'hF, 1, 32'h0, 0, ow, ord, oe);
    reset = 1;
    idle(1);
    xfer(1, 0, 32'h20, 32'h0, 4'h0, 0, 0);
    chk("t5_old_value", last_ack_rd, 32'h5A5A1234);
    chk("t5_err_cleared", {31'd0, last_err}, 32'h0);
    rnd(40, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
